// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the CPU data-memory port.
// Accepts one load/store at a time over valid/ready, waits WAIT_CYCLES,
// performs the access on an internal word-organised array and returns a
// single response beat that is held until the requester takes it.
// Optional build macro: DMEM_BUSERR_EN enables misalignment / reserved-op
// error reporting; without it accesses are force-aligned and rsp_err is 0.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_op,
    input  logic        req_ext,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [1:0] OP_WORD = 2'b00;
    localparam logic [1:0] OP_HALF = 2'b01;
    localparam logic [1:0] OP_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic                    write_r;
    logic [ADDR_WIDTH+1:0]   addr_r;
    logic [1:0]              op_r;
    logic                    ext_r;
    logic [31:0]             wdata_r;
    logic                    req_ready_r;
    logic                    rsp_valid_r;
    logic [31:0]             rsp_rdata_r;
    logic                    rsp_err_r;
    logic [31:0]             mem_r [DEPTH];

    logic [ADDR_WIDTH-1:0]   widx_s;
    logic [1:0]              lane_s;
    logic                    err_s;
    logic                    access_s;
    logic                    mem_we_s;
    logic [31:0]             load_s;
    logic                    unused_s;

    // Byte-enable pattern for the addressed lanes (little-endian).
    function automatic logic [3:0] lane_mask(input logic [1:0] op, input logic [1:0] lane);
        logic [3:0] m;
        case (op)
            OP_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
            OP_BYTE: m = 4'b0001 << lane;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Move right-aligned store data onto its byte lanes.
    function automatic logic [31:0] place_store(input logic [1:0] op, input logic [1:0] lane,
                                                input logic [31:0] wd);
        logic [31:0] r;
        case (op)
            OP_HALF: r = lane[1] ? {wd[15:0], 16'h0000} : {16'h0000, wd[15:0]};
            OP_BYTE: r = {4{wd[7:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Replace only the enabled bytes of the old word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word, input logic [31:0] new_word,
                                                input logic [3:0] be);
        logic [31:0] r;
        r = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Pick the addressed lanes of a word and extend to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] op,
                                                 input logic [1:0] lane, input logic ext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_HALF: r = {{16{ext & h[15]}}, h};
            OP_BYTE: r = {{24{ext & b[7]}}, b};
            default: r = word;
        endcase
        return r;
    endfunction

    assign unused_s = ^req_addr[31:ADDR_WIDTH+2];
    assign widx_s   = addr_r[ADDR_WIDTH+1:2];
    assign access_s = (state_r == ST_WAIT) && (cnt_r == 4'd0);
    assign mem_we_s = access_s && write_r && !err_s;

`ifdef DMEM_BUSERR_EN
    // Classify the latched request: misaligned word/halfword or reserved op.
    always_comb begin
        lane_s = addr_r[1:0];
        case (op_r)
            OP_WORD: err_s = (addr_r[1:0] != 2'b00);
            OP_HALF: err_s = addr_r[0];
            OP_BYTE: err_s = 1'b0;
            default: err_s = 1'b1;
        endcase
    end
`else
    // Force-align the latched address; the reserved op behaves as a word.
    always_comb begin
        err_s = 1'b0;
        case (op_r)
            OP_HALF: lane_s = {addr_r[1], 1'b0};
            OP_BYTE: lane_s = addr_r[1:0];
            default: lane_s = 2'b00;
        endcase
    end
`endif

    // Load data as it would be returned from the currently addressed word.
    always_comb begin
        load_s = extract_load(mem_r[widx_s], op_r, lane_s, ext_r);
    end

    // Array write port; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[widx_s] <= merge_bytes(mem_r[widx_s], place_store(op_r, lane_s, wdata_r),
                                         lane_mask(op_r, lane_s));
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            write_r     <= 1'b0;
            addr_r      <= '0;
            op_r        <= 2'b00;
            ext_r       <= 1'b0;
            wdata_r     <= 32'h0000_0000;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_r     <= req_write;
                        addr_r      <= req_addr[ADDR_WIDTH+1:0];
                        op_r        <= req_op;
                        ext_r       <= req_ext;
                        wdata_r     <= req_wdata;
                        cnt_r       <= 4'(WAIT_CYCLES);
                        req_ready_r <= 1'b0;
                        state_r     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        rsp_rdata_r <= (write_r || err_s) ? 32'h0000_0000 : load_s;
                        rsp_err_r   <= err_s;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= 32'h0000_0000;
                        rsp_err_r   <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= 32'h0000_0000;
                    rsp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic compared against a byte-addressed reference memory model.
module tb_dmem_responder;

    localparam int AW        = 10;
    localparam int WAITC     = 2;
    localparam int NBYTES    = 4 << AW;
    localparam int EXP_LAT   = WAITC + 1;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_op;
    logic        req_ext;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp;
    int n_bad;

    logic [7:0] mb [NBYTES];

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAITC)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_op    (req_op),
        .req_ext   (req_ext),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: byte-addressed little-endian memory, sizes in bytes.
    task automatic model_access(input logic w, input logic [31:0] a, input logic [1:0] op,
                                input logic e, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
        int unsigned nb;
        int unsigned ab;
        int unsigned base;
        nb = (op == 2'b01) ? 2 : ((op == 2'b10) ? 1 : 4);
        ab = a % NBYTES;
`ifdef DMEM_BUSERR_EN
        er = (op == 2'b11) || ((ab % nb) != 0);
`else
        er = 1'b0;
`endif
        base = ab - (ab % nb);
        rd = 32'h0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < int'(nb); i++) mb[base + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < int'(nb); i++) rd = rd | (32'(mb[base + i]) << (8*i));
                if (e && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8*nb));
            end
        end
    endtask

    // Drive one transaction, hold the response for 'hold' cycles, then accept it.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [1:0] op,
                          input logic e, input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic [31:0] exp_rd, output logic exp_er);
        for (int k = 0; k < 20 && !req_ready; k++) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b1; req_write = w; req_addr = a; req_op = op; req_ext = e; req_wdata = wd;
        @(posedge clk); #1;
        model_access(w, a, op, e, wd, exp_rd, exp_er);
        req_valid = 1'b0; req_write = $urandom_range(0, 1); req_addr = $urandom;
        req_op = 2'($urandom_range(0, 3)); req_ext = $urandom_range(0, 1); req_wdata = $urandom;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (lat > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_word_roundtrip();
        logic [31:0] rd, erd; logic er, eer; int lat;
        do_txn(1'b1, 32'h10, 2'b00, 1'b0, 32'hDEAD_BEEF, 0, rd, er, lat, erd, eer);
        n_cmp++; if (lat != EXP_LAT) begin n_bad++; $display("FAIL word_store_latency: got %0d want %0d", lat, EXP_LAT); end
        n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_bad++; $display("FAIL word_store_rsp: got %h/%b want 0/0", rd, er); end
        do_txn(1'b0, 32'h10, 2'b00, 1'b0, 32'h0, 1, rd, er, lat, erd, eer);
        n_cmp++; if (lat != EXP_LAT) begin n_bad++; $display("FAIL word_load_latency: got %0d want %0d", lat, EXP_LAT); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL word_load_data: got %h want deadbeef", rd); end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd, erd; logic er, eer; int lat;
        do_txn(1'b1, 32'h20, 2'b00, 1'b0, 32'h1122_3344, 0, rd, er, lat, erd, eer);
        do_txn(1'b1, 32'h21, 2'b10, 1'b0, 32'hABCD_EF80, 0, rd, er, lat, erd, eer);
        do_txn(1'b0, 32'h21, 2'b10, 1'b1, 32'h0, 0, rd, er, lat, erd, eer);
        n_cmp++; if (rd !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL byte_load_signed: got %h want ffffff80", rd); end
        do_txn(1'b0, 32'h21, 2'b10, 1'b0, 32'h0, 0, rd, er, lat, erd, eer);
        n_cmp++; if (rd !== 32'h0000_0080) begin n_bad++; $display("FAIL byte_load_zero: got %h want 00000080", rd); end
        do_txn(1'b0, 32'h22, 2'b01, 1'b1, 32'h0, 0, rd, er, lat, erd, eer);
        n_cmp++; if (rd !== 32'h0000_1122) begin n_bad++; $display("FAIL half_load_signed: got %h want 00001122", rd); end
        do_txn(1'b0, 32'h20, 2'b00, 1'b0, 32'h0, 0, rd, er, lat, erd, eer);
        n_cmp++; if (rd !== 32'h1122_8044) begin n_bad++; $display("FAIL word_after_merge: got %h want 11228044", rd); end
        do_txn(1'b0, 32'h22, 2'b01, 1'b0, 32'h0, 0, rd, er, lat, erd, eer);
        n_cmp++; if (rd !== 32'h0000_1122) begin n_bad++; $display("FAIL half_load_zero: got %h want 00001122", rd); end
        do_txn(1'b1, 32'h60, 2'b00, 1'b0, 32'h0000_8000, 0, rd, er, lat, erd, eer);
        do_txn(1'b0, 32'h60, 2'b01, 1'b1, 32'h0, 0, rd, er, lat, erd, eer);
        n_cmp++; if (rd !== 32'hFFFF_8000) begin n_bad++; $display("FAIL half_sign_bit15: got %h want ffff8000", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, erd; logic er, eer; int lat;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_op = 2'b00; req_ext = 1'b0;
        @(posedge clk); #1;
        model_access(1'b0, 32'h20, 2'b00, 1'b0, 32'h0, erd, eer);
        req_valid = 1'b0;
        for (int k = 0; k < 40 && !rsp_valid; k++) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_op = 2'b00; req_wdata = 32'h5555_5555;
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== erd || req_ready !== 1'b0) begin
                n_bad++; $display("FAIL backpressure_hold: cycle %0d valid=%b data=%h ready=%b want 1/%h/0",
                                  k, rsp_valid, rsp_rdata, req_ready, erd);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL backpressure_release: ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
        do_txn(1'b0, 32'h20, 2'b00, 1'b0, 32'h0, 0, rd, er, lat, erd, eer);
        n_cmp++; if (rd !== 32'h1122_8044) begin n_bad++; $display("FAIL backpressure_ignored_store: got %h want 11228044", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd, erd; logic er, eer; int lat;
        do_txn(1'b1, 32'h30, 2'b00, 1'b0, 32'h0102_0304, 0, rd, er, lat, erd, eer);
        do_txn(1'b1, 32'h31, 2'b00, 1'b0, 32'hAAAA_AAAA, 0, rd, er, lat, erd, eer);
`ifdef DMEM_BUSERR_EN
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL misaligned_store_err: got %b want 1", er); end
        do_txn(1'b0, 32'h30, 2'b00, 1'b0, 32'h0, 0, rd, er, lat, erd, eer);
        n_cmp++; if (rd !== 32'h0102_0304) begin n_bad++; $display("FAIL misaligned_no_write: got %h want 01020304", rd); end
        do_txn(1'b0, 32'h23, 2'b01, 1'b1, 32'h0, 0, rd, er, lat, erd, eer);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL misaligned_half_load: got %h/%b want 0/1", rd, er); end
        do_txn(1'b0, 32'h30, 2'b11, 1'b0, 32'h0, 0, rd, er, lat, erd, eer);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL reserved_op: got %h/%b want 0/1", rd, er); end
`else
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL misaligned_store_err: got %b want 0", er); end
        do_txn(1'b0, 32'h30, 2'b00, 1'b0, 32'h0, 0, rd, er, lat, erd, eer);
        n_cmp++; if (rd !== 32'hAAAA_AAAA) begin n_bad++; $display("FAIL force_aligned_write: got %h want aaaaaaaa", rd); end
        do_txn(1'b0, 32'h23, 2'b01, 1'b0, 32'h0, 0, rd, er, lat, erd, eer);
        n_cmp++; if (er !== 1'b0 || rd !== 32'h0000_1122) begin n_bad++; $display("FAIL force_aligned_half: got %h/%b want 00001122/0", rd, er); end
        do_txn(1'b0, 32'h30, 2'b11, 1'b0, 32'h0, 0, rd, er, lat, erd, eer);
        n_cmp++; if (er !== 1'b0 || rd !== 32'hAAAA_AAAA) begin n_bad++; $display("FAIL reserved_op_as_word: got %h/%b want aaaaaaaa/0", rd, er); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; logic er, eer; int lat; int seen;
        do_txn(1'b1, 32'h40, 2'b00, 1'b0, 32'h0, 0, rd, er, lat, erd, eer);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_op = 2'b00; req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_mid_async: valid=%b ready=%b want 0/1", rsp_valid, req_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL reset_mid_no_rsp: saw %0d valid cycles want 0", seen); end
        do_txn(1'b0, 32'h40, 2'b00, 1'b0, 32'h0, 0, rd, er, lat, erd, eer);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_mid_no_write: got %h want 0", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a; logic er, eer; int lat;
        for (int i = 0; i < 64; i += 4) begin
            a = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'(i));
            do_txn(1'b1, a, 2'b00, 1'b0, $urandom, 0, rd, er, lat, erd, eer);
        end
        for (int i = 0; i < 150; i++) begin
            a = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63)));
            do_txn(1'(($urandom_range(0, 1))), a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom_range(0, 3), rd, er, lat, erd, eer);
            n_cmp++; if (lat != EXP_LAT) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, EXP_LAT); end
            n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL rand_rdata[%0d]: addr %h got %h want %h", i, a, rd, erd); end
            n_cmp++; if (er !== eer) begin n_bad++; $display("FAIL rand_err[%0d]: addr %h got %b want %b", i, a, er, eer); end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_op = 2'b00;
        req_ext = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b0;
        test_reset();
        test_word_roundtrip();
        test_byte_half();
        test_backpressure();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
